regfile_commit_write_buffer: RTL and testbench

- Sits directly upstream of the FPGA register file, between the commit stage and the register-file write port.
- Accepts up to NR_COMMIT_PORTS architectural writes per cycle into a small circular FIFO.
- Drains the FIFO to a single register-file write port, one entry per cycle, so the register file needs only one distributed-RAM block.
- Forwards still-pending writes to the register-file read ports, so readers always see the architecturally newest value.

---
 rtl/regfile_commit_write_buffer.sv | 106 ++++++++++
 tb/tb_regfile_commit_write_buffer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_commit_write_buffer.sv
// rtl/regfile_commit_write_buffer.sv - multi-port commit FIFO draining to one register-file write port
// Pending writes are forwarded to the read ports so readers always see the newest value.
module regfile_commit_write_buffer #(
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned NR_READ_PORTS   = 2,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned DEPTH           = 4
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic [NR_COMMIT_PORTS-1:0]                  we_i,
   input  logic [NR_COMMIT_PORTS-1:0][4:0]             waddr_i,
   input  logic [NR_COMMIT_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
   output logic                                        ready_o,
   output logic                                        rf_we_o,
   output logic [4:0]                                  rf_waddr_o,
   output logic [DATA_WIDTH-1:0]                       rf_wdata_o,
   input  logic [NR_READ_PORTS-1:0][4:0]               raddr_i,
   input  logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]    rf_rdata_i,
   output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]    rdata_o,
   output logic                                        empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DEPTH-1:0][4:0]            addr_q, addr_d;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
   logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]                 count_q, count_d;
   logic [CNT_W-1:0]                 push_cnt;
   logic [PTR_W-1:0]                 wslot;
   logic [PTR_W-1:0]                 rslot;
   logic                             pop;

   assign ready_o    = (CNT_W'(DEPTH) - count_q) >= CNT_W'(NR_COMMIT_PORTS);
   assign empty_o    = (count_q == '0);
   assign pop        = (count_q != '0);
   assign rf_we_o    = pop;
   assign rf_waddr_o = addr_q[rd_ptr_q];
   assign rf_wdata_o = data_q[rd_ptr_q];

   // Pushes are gated by ready_o so a protocol violation can never overrun the pointers.
   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      push_cnt = '0;
      wslot    = '0;
      for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
         if (ready_o && we_i[p] && (waddr_i[p] != 5'd0)) begin
            wslot         = wr_ptr_q + push_cnt[PTR_W-1:0];
            addr_d[wslot] = waddr_i[p];
            data_d[wslot] = wdata_i[p];
            push_cnt      = push_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + push_cnt[PTR_W-1:0];
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q - CNT_W'(pop) + push_cnt;
   end

   // Walk oldest to youngest so the last match (the youngest) wins.
   always_comb begin
      rdata_o = rf_rdata_i;
      rslot   = '0;
      for (int k = 0; k < int'(NR_READ_PORTS); k++) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            rslot = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[rslot] == raddr_i[k])) begin
               rdata_o[k] = data_q[rslot];
            end
         end
         if (raddr_i[k] == 5'd0) begin
            rdata_o[k] = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (ready_o || !(|we_i));
      end
   end

endmodule

// File: tb/tb_regfile_commit_write_buffer.sv
// tb/tb_regfile_commit_write_buffer.sv - directed bench for regfile_commit_write_buffer
// A small register-file model captures rf_* writes and supplies rf_rdata_i.
module tb_regfile_commit_write_buffer;

   logic             clk_i;
   logic             rst_ni;
   logic [1:0]       we_i;
   logic [1:0][4:0]  waddr_i;
   logic [1:0][63:0] wdata_i;
   logic             ready_o;
   logic             rf_we_o;
   logic [4:0]       rf_waddr_o;
   logic [63:0]      rf_wdata_o;
   logic [1:0][4:0]  raddr_i;
   logic [1:0][63:0] rf_rdata_i;
   logic [1:0][63:0] rdata_o;
   logic             empty_o;

   logic [63:0]      rf_model [32];
   int               checks;
   int               errors;

   regfile_commit_write_buffer #(
      .NR_COMMIT_PORTS (2),
      .NR_READ_PORTS   (2),
      .DATA_WIDTH      (64),
      .DEPTH           (4)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .we_i       (we_i),
      .waddr_i    (waddr_i),
      .wdata_i    (wdata_i),
      .ready_o    (ready_o),
      .rf_we_o    (rf_we_o),
      .rf_waddr_o (rf_waddr_o),
      .rf_wdata_o (rf_wdata_o),
      .raddr_i    (raddr_i),
      .rf_rdata_i (rf_rdata_i),
      .rdata_o    (rdata_o),
      .empty_o    (empty_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (rf_we_o) rf_model[rf_waddr_o] <= rf_wdata_o;
   end

   always_comb begin
      rf_rdata_i[0] = rf_model[raddr_i[0]];
      rf_rdata_i[1] = rf_model[raddr_i[1]];
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] we, input logic [4:0] a0, input logic [63:0] d0,
                        input logic [4:0] a1, input logic [63:0] d1);
      we_i       = we;
      waddr_i[0] = a0;
      wdata_i[0] = d0;
      waddr_i[1] = a1;
      wdata_i[1] = d1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int r = 0; r < 32; r++) rf_model[r] = '0;
      rst_ni  = 1'b0;
      raddr_i = '0;
      drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);

      // reset state
      #1;
      chk("rst_ready", 64'(ready_o), 64'd1);
      chk("rst_empty", 64'(empty_o), 64'd1);
      chk("rst_rf_we", 64'(rf_we_o), 64'd0);
      #11;
      rst_ni = 1'b1;

      // single write x5=0xAA, visible for exactly one cycle
      drive(2'b01, 5'd5, 64'hAA, 5'd0, 64'h0);
      tick();
      drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
      chk("single_we",    64'(rf_we_o), 64'd1);
      chk("single_waddr", 64'(rf_waddr_o), 64'd5);
      chk("single_wdata", rf_wdata_o, 64'hAA);
      chk("single_empty", 64'(empty_o), 64'd0);
      tick();
      chk("single_we_off", 64'(rf_we_o), 64'd0);
      chk("single_empty2", 64'(empty_o), 64'd1);
      chk("single_rf",     rf_model[5], 64'hAA);

      // dual commit to x7: port1 is younger
      drive(2'b11, 5'd7, 64'h1, 5'd7, 64'h2);
      tick();
      drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
      raddr_i[0] = 5'd7;
      raddr_i[1] = 5'd5;
      #1;
      chk("dual_byp7",   rdata_o[0], 64'h2);
      chk("dual_rf5",    rdata_o[1], 64'hAA);
      chk("dual_waddr0", 64'(rf_waddr_o), 64'd7);
      chk("dual_wdata0", rf_wdata_o, 64'h1);
      tick();
      chk("dual_waddr1", 64'(rf_waddr_o), 64'd7);
      chk("dual_wdata1", rf_wdata_o, 64'h2);
      chk("dual_byp7b",  rdata_o[0], 64'h2);
      tick();
      chk("dual_empty",  64'(empty_o), 64'd1);
      chk("dual_rf7",    rf_model[7], 64'h2);
      chk("dual_read7",  rdata_o[0], 64'h2);

      // x0 filter
      drive(2'b11, 5'd0, 64'hFF, 5'd3, 64'h9);
      tick();
      drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
      raddr_i[0] = 5'd0;
      raddr_i[1] = 5'd3;
      #1;
      chk("x0_waddr", 64'(rf_waddr_o), 64'd3);
      chk("x0_wdata", rf_wdata_o, 64'h9);
      chk("x0_rd0",   rdata_o[0], 64'h0);
      chk("x0_byp3",  rdata_o[1], 64'h9);
      tick();
      chk("x0_empty", 64'(empty_o), 64'd1);
      chk("x0_rd0b",  rdata_o[0], 64'h0);

      // fill and backpressure
      drive(2'b11, 5'd10, 64'h100, 5'd11, 64'h101);
      tick();
      chk("fill_ready_c2", 64'(ready_o), 64'd1);
      chk("fill_waddr_a",  64'(rf_waddr_o), 64'd10);
      chk("fill_wdata_a",  rf_wdata_o, 64'h100);
      drive(2'b11, 5'd12, 64'h102, 5'd13, 64'h103);
      tick();
      drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
      raddr_i[0] = 5'd13;
      #1;
      chk("fill_ready_c3", 64'(ready_o), 64'd0);
      chk("fill_waddr_b",  64'(rf_waddr_o), 64'd11);
      chk("fill_byp13",    rdata_o[0], 64'h103);
      tick();
      chk("fill_ready_back", 64'(ready_o), 64'd1);
      chk("fill_waddr_c",    64'(rf_waddr_o), 64'd12);
      chk("fill_wdata_c",    rf_wdata_o, 64'h102);
      tick();
      chk("fill_waddr_d", 64'(rf_waddr_o), 64'd13);
      chk("fill_wdata_d", rf_wdata_o, 64'h103);
      tick();
      chk("fill_empty", 64'(empty_o), 64'd1);
      chk("fill_rf11",  rf_model[11], 64'h101);

      // pointer wrap: x1..x10 single writes, data i*0x10
      raddr_i[0] = 5'd9;
      for (int i = 1; i <= 10; i++) begin
         drive(2'b01, 5'(i), 64'(i * 16), 5'd0, 64'h0);
         tick();
         chk("wrap_waddr", 64'(rf_waddr_o), 64'(i));
         chk("wrap_wdata", rf_wdata_o, 64'(i * 16));
         if (i == 9) chk("wrap_byp9", rdata_o[0], 64'h90);
      end
      drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
      tick();
      chk("wrap_empty", 64'(empty_o), 64'd1);
      chk("wrap_rf4",   rf_model[4], 64'h40);

      // mid-operation reset with 3 entries pending
      drive(2'b11, 5'd20, 64'h200, 5'd21, 64'h201);
      tick();
      drive(2'b11, 5'd22, 64'h202, 5'd23, 64'h203);
      tick();
      drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0);
      chk("mrst_pre_empty", 64'(empty_o), 64'd0);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("mrst_rf_we", 64'(rf_we_o), 64'd0);
      chk("mrst_empty", 64'(empty_o), 64'd1);
      chk("mrst_ready", 64'(ready_o), 64'd1);
      tick();
      rst_ni = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("mrst_no_stale", 64'(rf_we_o), 64'd0);
      end
      raddr_i[0] = 5'd23;
      raddr_i[1] = 5'd21;
      #1;
      chk("mrst_rd23", rdata_o[0], 64'h0);
      chk("mrst_rd21", rdata_o[1], 64'h0);
      chk("mrst_rf20", rf_model[20], 64'h200);
      chk("mrst_rf22", rf_model[22], 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
